// File: rtl/input_debounce.sv
// Six-channel pad input conditioner: two-flop synchronizer followed by a per-channel counter debouncer.
// Optional rising-edge pulse outputs are built when DEBOUNCE_EDGE_EN is defined.
module input_debounce #(
   parameter int WIDTH           = 6,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int CNT_W           = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] rise,
   output logic             stable
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync0;
   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] mismatch;
   logic [WIDTH-1:0] flip;
   logic [CNT_W-1:0] cnt [WIDTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync0 <= '0;
         sync1 <= '0;
      end else begin
         sync0 <= din;
         sync1 <= sync0;
      end
   end

   assign mismatch = sync1 ^ dout;
   assign stable   = ~|mismatch;

   always_comb begin
      flip = '0;
      for (int i = 0; i < WIDTH; i++) begin
         flip[i] = mismatch[i] && (cnt[i] == TERM);
      end
   end

   // Counter only advances while the channel disagrees, so it saturates at TERM and never wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (!mismatch[i]) begin
               cnt[i] <= '0;
            end else if (flip[i]) begin
               cnt[i]  <= '0;
               dout[i] <= sync1[i];
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

`ifdef DEBOUNCE_EDGE_EN
   logic [WIDTH-1:0] rise_q;

   // Pulse coincides with the edge on which dout goes 0->1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rise_q <= '0;
      end else begin
         rise_q <= flip & sync1;
      end
   end

   assign rise = rise_q;
`else
   assign rise = '0;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: latency, glitch/bounce rejection, channel independence,
// reset mid-count and the optional rising-edge pulses.
module tb_input_debounce;

`ifdef DEBOUNCE_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic [5:0] din;
   logic [5:0] dout;
   logic [5:0] rise;
   logic       stable;

   int n_tests = 0;
   int n_fail  = 0;

   input_debounce #(
      .WIDTH(6),
      .DEBOUNCE_CYCLES(8),
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .din(din),
      .dout(dout),
      .rise(rise),
      .stable(stable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      n_tests++;
      if (dout !== 6'h00) begin n_fail++; $display("FAIL reset_dout got=%h exp=00", dout); end
      n_tests++;
      if (rise !== 6'h00) begin n_fail++; $display("FAIL reset_rise got=%h exp=00", rise); end
      n_tests++;
      if (stable !== 1'b1) begin n_fail++; $display("FAIL reset_stable got=%b exp=1", stable); end
      din = 6'h3F;
      step();
      step();
      n_tests++;
      if (dout !== 6'h00) begin n_fail++; $display("FAIL reset_hold_dout got=%h exp=00", dout); end
      n_tests++;
      if (stable !== 1'b1) begin n_fail++; $display("FAIL reset_hold_stable got=%b exp=1", stable); end
   endtask

   task automatic test_power_up();
      logic [5:0] exp_rise;
      reset = 1'b0;
      din   = 6'h3F;
      for (int e = 1; e <= 11; e++) begin
         step();
         exp_rise = (EDGE_EN && e == 10) ? 6'h3F : 6'h00;
         n_tests++;
         if (dout !== ((e >= 10) ? 6'h3F : 6'h00)) begin
            n_fail++; $display("FAIL pwr_dout edge=%0d got=%h", e, dout);
         end
         n_tests++;
         if (stable !== (e == 1 || e >= 10)) begin
            n_fail++; $display("FAIL pwr_stable edge=%0d got=%b", e, stable);
         end
         n_tests++;
         if (rise !== exp_rise) begin
            n_fail++; $display("FAIL pwr_rise edge=%0d got=%h exp=%h", e, rise, exp_rise);
         end
      end
      din = 6'h00;
      for (int e = 1; e <= 12; e++) begin
         step();
         n_tests++;
         if (dout !== ((e >= 10) ? 6'h00 : 6'h3F)) begin
            n_fail++; $display("FAIL pwr_fall_dout edge=%0d got=%h", e, dout);
         end
         n_tests++;
         if (rise !== 6'h00) begin n_fail++; $display("FAIL pwr_fall_rise edge=%0d got=%h exp=00", e, rise); end
      end
   endtask

   task automatic test_glitch();
      din = 6'h01;
      for (int e = 1; e <= 12; e++) begin
         step();
         if (e == 5) din = 6'h00;
         n_tests++;
         if (dout !== 6'h00) begin n_fail++; $display("FAIL glitch_dout edge=%0d got=%h exp=00", e, dout); end
         n_tests++;
         if (stable !== !(e >= 2 && e <= 6)) begin
            n_fail++; $display("FAIL glitch_stable edge=%0d got=%b", e, stable);
         end
      end
   endtask

   task automatic test_bounce();
      for (int t = 0; t < 6; t++) begin
         din = (t % 2 == 0) ? 6'h04 : 6'h00;
         step();
         n_tests++;
         if (dout !== 6'h00) begin n_fail++; $display("FAIL bounce_toggle t=%0d got=%h exp=00", t, dout); end
      end
      din = 6'h04;
      for (int e = 1; e <= 11; e++) begin
         step();
         n_tests++;
         if (dout !== ((e >= 10) ? 6'h04 : 6'h00)) begin
            n_fail++; $display("FAIL bounce_dout edge=%0d got=%h", e, dout);
         end
      end
      din = 6'h00;
      for (int e = 1; e <= 12; e++) step();
      n_tests++;
      if (dout !== 6'h00) begin n_fail++; $display("FAIL bounce_clear got=%h exp=00", dout); end
   endtask

   task automatic test_independence();
      logic [5:0] exp_dout;
      logic [5:0] exp_rise;
      din = 6'h02;
      for (int e = 1; e <= 14; e++) begin
         if (e == 4) din = 6'h12;
         step();
         exp_dout = {1'b0, (e >= 13), 2'b00, (e >= 10), 1'b0};
         exp_rise = {1'b0, EDGE_EN && (e == 13), 2'b00, EDGE_EN && (e == 10), 1'b0};
         n_tests++;
         if (dout !== exp_dout) begin
            n_fail++; $display("FAIL indep_rise_dout edge=%0d got=%h exp=%h", e, dout, exp_dout);
         end
         n_tests++;
         if (rise !== exp_rise) begin
            n_fail++; $display("FAIL indep_rise_pulse edge=%0d got=%h exp=%h", e, rise, exp_rise);
         end
      end
      din = 6'h10;
      for (int e = 1; e <= 14; e++) begin
         if (e == 4) din = 6'h00;
         step();
         exp_dout = {1'b0, (e < 13), 2'b00, (e < 10), 1'b0};
         n_tests++;
         if (dout !== exp_dout) begin
            n_fail++; $display("FAIL indep_fall_dout edge=%0d got=%h exp=%h", e, dout, exp_dout);
         end
         n_tests++;
         if (rise !== 6'h00) begin n_fail++; $display("FAIL indep_fall_pulse edge=%0d got=%h exp=00", e, rise); end
      end
   endtask

   task automatic test_reset_mid_count();
      din = 6'h3E;
      for (int e = 1; e <= 12; e++) step();
      n_tests++;
      if (dout !== 6'h3E) begin n_fail++; $display("FAIL rmid_pre_dout got=%h exp=3e", dout); end
      din = 6'h01;
      for (int e = 1; e <= 6; e++) step();
      n_tests++;
      if (stable !== 1'b0) begin n_fail++; $display("FAIL rmid_counting_stable got=%b exp=0", stable); end
      reset = 1'b1;
      #1;
      n_tests++;
      if (dout !== 6'h00) begin n_fail++; $display("FAIL rmid_async_dout got=%h exp=00", dout); end
      n_tests++;
      if (stable !== 1'b1) begin n_fail++; $display("FAIL rmid_async_stable got=%b exp=1", stable); end
      step();
      reset = 1'b0;
      for (int e = 1; e <= 11; e++) begin
         step();
         n_tests++;
         if (dout !== ((e >= 10) ? 6'h01 : 6'h00)) begin
            n_fail++; $display("FAIL rmid_after_dout edge=%0d got=%h", e, dout);
         end
      end
   endtask

   task automatic test_edge_pulse();
      logic [5:0] exp_rise;
      din = 6'h00;
      for (int e = 1; e <= 12; e++) step();
      n_tests++;
      if (dout !== 6'h00) begin n_fail++; $display("FAIL edge_pre_dout got=%h exp=00", dout); end
      din = 6'h20;
      for (int e = 1; e <= 12; e++) begin
         step();
         exp_rise = (EDGE_EN && e == 10) ? 6'h20 : 6'h00;
         n_tests++;
         if (rise !== exp_rise) begin
            n_fail++; $display("FAIL edge_rise edge=%0d got=%h exp=%h", e, rise, exp_rise);
         end
         n_tests++;
         if (dout !== ((e >= 10) ? 6'h20 : 6'h00)) begin
            n_fail++; $display("FAIL edge_dout edge=%0d got=%h", e, dout);
         end
      end
      din = 6'h00;
      for (int e = 1; e <= 12; e++) begin
         step();
         n_tests++;
         if (rise !== 6'h00) begin n_fail++; $display("FAIL edge_fall_rise edge=%0d got=%h exp=00", e, rise); end
         n_tests++;
         if (dout !== ((e >= 10) ? 6'h00 : 6'h20)) begin
            n_fail++; $display("FAIL edge_fall_dout edge=%0d got=%h", e, dout);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      din   = 6'h00;
      test_reset();
      test_power_up();
      test_glitch();
      test_bounce();
      test_independence();
      test_reset_mid_count();
      test_edge_pulse();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
